exposure_sequencer: RTL and testbench

Pixel-clock-domain controller that sequences camera exposure for HDR capture. It consumes the per-frame `change_exp` pulse from the capture block and steps through a three-entry exposure table (short, mid, long). Each step is written to the camera's AEC registers through a single-request SCCB write master. It also switches the camera's automatic exposure off and on as `hdr_en` toggles, and reports which exposure is in force.

---
 rtl/exposure_sequencer_pkg.sv | 30 +++
 rtl/exposure_sequencer_exp_write_list.sv | 60 ++++++
 rtl/exposure_sequencer.sv | 172 +++++++++++++++++
 tb/tb_exposure_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exposure_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exposure_sequencer_pkg
// Description : OV7670 register map, sequencer state type and exposure table
//               type shared by the exposure sequencer files.
// Revision    : 1.0 - initial release
// ============================================================================
package exposure_sequencer_pkg;

    localparam logic [7:0] c_ADDR_COM1  = 8'h04;
    localparam logic [7:0] c_ADDR_AECHH = 8'h07;
    localparam logic [7:0] c_ADDR_AECH  = 8'h10;
    localparam logic [7:0] c_ADDR_COM8  = 8'h13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        NEXT  = 2'd3
    } state_t;

    // Entry 0 is the short exposure, entry 2 the long one.
    typedef logic [2:0][15:0] exp_table_t;

    function automatic logic [1:0] next_index(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exposure_sequencer_exp_write_list.sv
`default_nettype none
// ============================================================================
// Module      : exp_write_list
// Description : Maps the active job (mode or exposure), target index and write
//               counter to the SCCB register address/data and last-entry flag.
// Revision    : 1.0 - initial release
// ============================================================================
module exp_write_list
    import exposure_sequencer_pkg::*;
#(
    parameter exp_table_t EXP_TABLE   = '0,
    parameter logic [7:0] COM8_MANUAL = 8'h8E,
    parameter logic [7:0] COM8_AUTO   = 8'h8F
) (
    input  logic       i_is_exp,
    input  logic [1:0] i_target,
    input  logic       i_mode_manual,
    input  logic [1:0] i_wr_cnt,
    output logic [7:0] o_addr,
    output logic [7:0] o_data,
    output logic       o_last
);

    logic [15:0] w_aec;

    always_comb begin
        case (i_target)
            2'd1:    w_aec = EXP_TABLE[1];
            2'd2:    w_aec = EXP_TABLE[2];
            default: w_aec = EXP_TABLE[0];
        endcase
    end

    always_comb begin
        o_addr = c_ADDR_COM8;
        o_data = i_mode_manual ? COM8_MANUAL : COM8_AUTO;
        o_last = 1'b1;
        if (i_is_exp) begin
            case (i_wr_cnt)
                2'd0: begin
                    o_addr = c_ADDR_AECHH;
                    o_data = {2'b00, w_aec[15:10]};
                    o_last = 1'b0;
                end
                2'd1: begin
                    o_addr = c_ADDR_AECH;
                    o_data = w_aec[9:2];
                    o_last = 1'b0;
                end
                default: begin
                    o_addr = c_ADDR_COM1;
                    o_data = {6'b000000, w_aec[1:0]};
                    o_last = 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/exposure_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exposure_sequencer
// Description : HDR exposure stepper; writes COM8 mode changes and AEC table
//               steps to the camera through a single-request SCCB master.
// Revision    : 1.0 - initial release
// ============================================================================
module exposure_sequencer
    import exposure_sequencer_pkg::*;
#(
    parameter logic [15:0] EXP_SHORT   = 16'h0040,
    parameter logic [15:0] EXP_MID     = 16'h0180,
    parameter logic [15:0] EXP_LONG    = 16'h0600,
    parameter logic [7:0]  COM8_MANUAL = 8'h8E,
    parameter logic [7:0]  COM8_AUTO   = 8'h8F
) (
    input  logic       p_clk,
    input  logic       rst_n,
    input  logic       hdr_en,
    input  logic       take_pic,
    input  logic       change_exp,
    input  logic       sccb_ack,
    output logic       sccb_req,
    output logic [7:0] sccb_addr,
    output logic [7:0] sccb_data,
    output logic [1:0] exp_index,
    output logic       busy,
    output logic       overrun
);

    localparam exp_table_t c_EXP_TABLE = {EXP_LONG, EXP_MID, EXP_SHORT};

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_hdr_q;
    logic       r_mode_pend;
    logic       r_exp_pend;
    logic       r_overrun;
    logic       r_cancel;
    logic       r_is_exp;
    logic       r_mode_manual;
    logic [1:0] r_exp_index;
    logic [1:0] r_target;
    logic [1:0] r_wr_cnt;

    logic       w_rise;
    logic       w_fall;
    logic       w_exp_req;
    logic       w_load_mode;
    logic       w_load_exp;
    logic       w_step_done;
    logic       w_req;
    logic       w_last;
    logic [7:0] w_addr;
    logic [7:0] w_data;

    assign w_rise    = hdr_en & ~r_hdr_q;
    assign w_fall    = ~hdr_en & r_hdr_q;
    assign w_exp_req = change_exp & ~take_pic & hdr_en;

    // A step cancelled by an hdr_en fall still finishes its writes but leaves
    // exp_index at 0.
    assign w_step_done = (r_state == WAIT) && sccb_ack && w_last && r_is_exp && !r_cancel;

    exp_write_list #(
        .EXP_TABLE   (c_EXP_TABLE),
        .COM8_MANUAL (COM8_MANUAL),
        .COM8_AUTO   (COM8_AUTO)
    ) u_write_list (
        .i_is_exp      (r_is_exp),
        .i_target      (r_target),
        .i_mode_manual (r_mode_manual),
        .i_wr_cnt      (r_wr_cnt),
        .o_addr        (w_addr),
        .o_data        (w_data),
        .o_last        (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load_mode = 1'b0;
        w_load_exp  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_mode_pend) begin
                    w_load_mode = 1'b1;
                    w_state_nxt = ISSUE;
                end else if (r_exp_pend) begin
                    w_load_exp  = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                if (sccb_ack) begin
                    w_state_nxt = NEXT;
                end
            end
            NEXT: w_state_nxt = w_last ? IDLE : ISSUE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_hdr_q       <= 1'b0;
            r_mode_pend   <= 1'b0;
            r_exp_pend    <= 1'b0;
            r_overrun     <= 1'b0;
            r_cancel      <= 1'b0;
            r_is_exp      <= 1'b0;
            r_mode_manual <= 1'b0;
            r_exp_index   <= 2'd0;
            r_target      <= 2'd0;
            r_wr_cnt      <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_hdr_q <= hdr_en;

            if (w_rise || w_fall) begin
                r_mode_pend <= 1'b1;
            end else if (w_load_mode) begin
                r_mode_pend <= 1'b0;
            end

            // exp_pend is a one-deep queue: it is consumed when the step is
            // loaded, so one further request may wait behind a running step.
            if (w_exp_req) begin
                r_exp_pend <= 1'b1;
            end else if (w_fall || w_load_exp) begin
                r_exp_pend <= 1'b0;
            end

            if (w_exp_req && r_exp_pend && !w_load_exp) begin
                r_overrun <= 1'b1;
            end

            if (w_fall) begin
                r_cancel <= 1'b1;
            end else if (w_load_mode || w_load_exp) begin
                r_cancel <= 1'b0;
            end

            if (w_fall) begin
                r_exp_index <= 2'd0;
            end else if (w_step_done) begin
                r_exp_index <= r_target;
            end

            if (w_load_mode || w_load_exp) begin
                r_is_exp      <= w_load_exp;
                r_target      <= next_index(r_exp_index);
                r_mode_manual <= r_hdr_q;
                r_wr_cnt      <= 2'd0;
            end else if (r_state == NEXT && !w_last) begin
                r_wr_cnt <= r_wr_cnt + 2'd1;
            end
        end
    end

    // Bus outputs decode straight from state so reset removes them at once.
    assign w_req     = (r_state == ISSUE) || (r_state == WAIT);
    assign sccb_req  = w_req;
    assign sccb_addr = w_req ? w_addr : 8'h00;
    assign sccb_data = w_req ? w_data : 8'h00;
    assign exp_index = r_exp_index;
    assign busy      = (r_state != IDLE);
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_exposure_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_exposure_sequencer
// Description : Scoreboard bench for exposure_sequencer with an SCCB responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exposure_sequencer;

    logic       p_clk = 1'b0;
    logic       rst_n;
    logic       hdr_en;
    logic       take_pic;
    logic       change_exp;
    logic       sccb_ack;
    logic       sccb_req;
    logic [7:0] sccb_addr;
    logic [7:0] sccb_data;
    logic [1:0] exp_index;
    logic       busy;
    logic       overrun;

    exposure_sequencer dut (
        .p_clk      (p_clk),
        .rst_n      (rst_n),
        .hdr_en     (hdr_en),
        .take_pic   (take_pic),
        .change_exp (change_exp),
        .sccb_ack   (sccb_ack),
        .sccb_req   (sccb_req),
        .sccb_addr  (sccb_addr),
        .sccb_data  (sccb_data),
        .exp_index  (exp_index),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 p_clk = ~p_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] sb_q[$];
    logic [15:0] mon_exp;
    int          ack_dly  = 3;
    int          m_idx    = 0;
    bit          m_hdr    = 1'b0;
    bit          m_ovr    = 1'b0;
    int          c_aec[3] = '{16'h0040, 16'h0180, 16'h0600};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge p_clk);
        #1;
    endtask

    // Reference: AEC value split across AECHH[5:0], AECH[7:0], COM1[1:0].
    task automatic push_step(input int idx);
        int aec;
        aec = c_aec[idx];
        sb_q.push_back({8'h07, 8'(aec / 1024)});
        sb_q.push_back({8'h10, 8'((aec / 4) % 256)});
        sb_q.push_back({8'h04, 8'(aec % 4)});
    endtask

    task automatic pulse_raw(input bit tp);
        take_pic   = tp;
        change_exp = 1'b1;
        tick();
        change_exp = 1'b0;
        take_pic   = 1'b0;
    endtask

    task automatic pulse_change(input bit tp);
        pulse_raw(tp);
        if (!tp && m_hdr) begin
            m_idx = (m_idx + 1) % 3;
            push_step(m_idx);
        end
    endtask

    task automatic set_hdr(input bit v);
        hdr_en = v;
        tick();
        if (v && !m_hdr) sb_q.push_back({8'h13, 8'h8E});
        if (!v && m_hdr) begin
            sb_q.push_back({8'h13, 8'h8F});
            m_idx = 0;
        end
        m_hdr = v;
    endtask

    task automatic wait_idle();
        int n;
        int quiet;
        n = 0;
        quiet = 0;
        while (quiet < 4 && n < 400) begin
            tick();
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 4) check("idle_timeout", 1, 0);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!sccb_req && n < 50) begin
            tick();
            n++;
        end
        if (!sccb_req) check("req_timeout", 0, 1);
    endtask

    // SCCB slave: acknowledges ack_dly cycles after req rises.
    initial begin : responder
        int cnt;
        cnt = 0;
        sccb_ack = 1'b0;
        forever begin
            @(posedge p_clk);
            #1;
            if (sccb_ack) begin
                sccb_ack = 1'b0;
                cnt = 0;
            end else if (sccb_req) begin
                cnt++;
                if (cnt >= ack_dly) sccb_ack = 1'b1;
            end else begin
                cnt = 0;
            end
        end
    end

    always @(negedge p_clk) begin
        if (rst_n && sccb_req && sccb_ack) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", {sccb_addr, sccb_data}, 0);
            end else begin
                mon_exp = sb_q.pop_front();
                check("sccb_write", {sccb_addr, sccb_data}, mon_exp);
            end
        end
    end

    initial begin : stim
        int  k;
        int  n;
        bit  seen_busy;
        rst_n = 1'b0; hdr_en = 1'b0; take_pic = 1'b0; change_exp = 1'b0;
        repeat (3) tick();
        check("rst_req", sccb_req, 0);
        check("rst_addr", sccb_addr, 0);
        check("rst_data", sccb_data, 0);
        check("rst_index", exp_index, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        tick();

        // Enable HDR: single COM8 manual write.
        set_hdr(1'b1);
        wait_idle();
        check("hdr_on_index", exp_index, 0);
        check("hdr_on_busy", busy, 0);

        // First step with fixed ack latency and cycle-exact checks.
        ack_dly = 3;
        pulse_change(1'b0);
        check("req_n1", sccb_req, 0);
        tick();
        check("req_n2", sccb_req, 1);
        k = 0; n = 0;
        while (k < 3 && n < 100) begin
            @(negedge p_clk);
            n++;
            if (sccb_ack && sccb_req) k++;
        end
        check("third_ack_seen", k, 3);
        check("index_at_ack", exp_index, 0);
        tick();
        check("index_after_ack", exp_index, 1);
        check("req_after_ack", sccb_req, 0);
        wait_idle();

        // Randomized operation mix, block drained between operations.
        for (int it = 0; it < 40; it++) begin
            ack_dly = $urandom_range(2, 5);
            k = $urandom_range(0, 9);
            if (k < 2) set_hdr(!m_hdr);
            else if (k < 9) pulse_change($urandom_range(0, 3) == 0);
            else repeat ($urandom_range(1, 4)) tick();
            wait_idle();
            check("rand_index", exp_index, m_idx);
            check("rand_overrun", overrun, m_ovr);
        end

        // Frozen request is ignored.
        set_hdr(1'b1);
        wait_idle();
        pulse_change(1'b1);
        seen_busy = 1'b0;
        repeat (5) begin
            tick();
            if (busy || sccb_req) seen_busy = 1'b1;
        end
        check("take_pic_ignored", seen_busy, 0);

        // Queue one request behind a running step, then overrun.
        ack_dly = 5;
        pulse_change(1'b0);
        wait_req();
        tick();
        pulse_change(1'b0);
        pulse_raw(1'b0);
        m_ovr = 1'b1;
        tick();
        check("overrun_set", overrun, 1);
        wait_idle();
        check("overrun_index", exp_index, m_idx);
        check("overrun_sticky", overrun, 1);

        // HDR off during a step: writes finish, then COM8 auto, index 0.
        ack_dly = 4;
        pulse_change(1'b0);
        wait_req();
        set_hdr(1'b0);
        check("fall_index_now", exp_index, 0);
        wait_idle();
        check("fall_index", exp_index, 0);

        // Asynchronous reset in the middle of a write.
        set_hdr(1'b1);
        wait_idle();
        ack_dly = 5;
        pulse_change(1'b0);
        wait_req();
        @(posedge p_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", sccb_req, 0);
        check("arst_addr", sccb_addr, 0);
        check("arst_data", sccb_data, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        check("arst_index", exp_index, 0);
        sb_q.delete();
        hdr_en = 1'b0;
        m_hdr = 1'b0; m_idx = 0; m_ovr = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("post_rst_busy", busy, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
